// File: rtl/segre_icache.sv
// segre_icache: direct-mapped, read-only instruction cache.
// The fetch lookup is combinational. A miss latches the line address,
// requests the whole line from memory, writes it and returns to LOOKUP,
// where the held fetch then hits.
//
// Memory handshake: mem_rd_o is high for every MISS cycle, and mem_addr_o
// holds the latched line address for that whole time. The cycle in which
// mem_ready_i is sampled high completes the transfer, and mem_rdata_i is
// captured in that same cycle. mem_ready_i has no effect in any other state.
module segre_icache #(
  parameter int ADDR_SIZE  = 32,
  parameter int WORD_SIZE  = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 4
) (
  input  logic                            clk_i,
  input  logic                            rsn_i,
  input  logic                            fetch_valid_i,
  input  logic [ADDR_SIZE-1:0]            fetch_addr_i,
  output logic                            ic_hit_o,
  output logic [WORD_SIZE-1:0]            instr_o,
  input  logic                            invalidate_i,
  output logic                            mem_rd_o,
  output logic [ADDR_SIZE-1:0]            mem_addr_o,
  input  logic                            mem_ready_i,
  input  logic [LINE_WORDS*WORD_SIZE-1:0] mem_rdata_i,
  output logic [31:0]                     miss_count_o,
  output logic [1:0]                      dbg_state_o
);

  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int LSB_W  = OFF_W + 2;
  localparam int TAG_W  = ADDR_SIZE - IDX_W - LSB_W;
  localparam int LINE_W = LINE_WORDS * WORD_SIZE;

  typedef enum logic [1:0] {
    S_LOOKUP = 2'd0,
    S_MISS   = 2'd1,
    S_REFILL = 2'd2
  } state_t;

  state_t                 r_state;
  logic [NUM_LINES-1:0]   r_valid;
  logic [TAG_W-1:0]       r_tag  [NUM_LINES];
  logic [LINE_W-1:0]      r_data [NUM_LINES];
  logic [LINE_W-1:0]      r_line_buf;
  logic [ADDR_SIZE-1:0]   r_miss_addr;
  logic                   r_drop;
  logic [31:0]            r_miss_count;

  logic [OFF_W-1:0]       w_word_sel;
  logic [IDX_W-1:0]       w_index;
  logic [TAG_W-1:0]       w_tag;
  logic                   w_hit;
  logic [LINE_W-1:0]      w_line;
  logic [IDX_W-1:0]       w_miss_idx;
  logic [TAG_W-1:0]       w_miss_tag;
  logic [1:0]             w_unused_bits;

  // Fetch address split into word select, index and tag.
  assign w_word_sel    = fetch_addr_i[LSB_W-1:2];
  assign w_index       = fetch_addr_i[LSB_W +: IDX_W];
  assign w_tag         = fetch_addr_i[ADDR_SIZE-1 -: TAG_W];
  assign w_unused_bits = fetch_addr_i[1:0];

  // The latched line address also carries the index and tag of the refill.
  assign w_miss_idx = r_miss_addr[LSB_W +: IDX_W];
  assign w_miss_tag = r_miss_addr[ADDR_SIZE-1 -: TAG_W];

  // Combinational lookup of the indexed line.
  assign w_line  = r_data[w_index];
  assign w_hit   = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign instr_o = w_line[w_word_sel*WORD_SIZE +: WORD_SIZE];

  // Outside LOOKUP the IF stage is always held.
  assign ic_hit_o     = (r_state == S_LOOKUP) ? (!fetch_valid_i || w_hit) : 1'b0;
  assign mem_rd_o     = (r_state == S_MISS);
  assign mem_addr_o   = (r_state == S_MISS) ? r_miss_addr : '0;
  assign miss_count_o = r_miss_count;
  assign dbg_state_o  = r_state;

  // Control FSM: state, valid bits, drop flag, miss address and miss counter.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      r_state      <= S_LOOKUP;
      r_valid      <= '0;
      r_drop       <= 1'b0;
      r_miss_count <= '0;
      r_miss_addr  <= '0;
    end else begin
      case (r_state)
        S_LOOKUP: begin
          if (invalidate_i) r_valid <= '0;
          if (fetch_valid_i && !w_hit) begin
            r_miss_addr  <= {fetch_addr_i[ADDR_SIZE-1:LSB_W], {LSB_W{1'b0}}};
            r_miss_count <= r_miss_count + 32'd1;
            r_state      <= S_MISS;
          end
        end
        S_MISS: begin
          // An invalidate while the line is in flight makes that line stale too.
          if (invalidate_i) begin
            r_valid <= '0;
            r_drop  <= 1'b1;
          end
          if (mem_ready_i) r_state <= S_REFILL;
        end
        S_REFILL: begin
          if (invalidate_i) r_valid <= '0;
          else              r_valid[w_miss_idx] <= !r_drop;
          r_drop  <= 1'b0;
          r_state <= S_LOOKUP;
        end
        default: r_state <= S_LOOKUP;
      endcase
    end
  end

  // Data path: the line buffer, data array and tags carry no reset; they are
  // qualified by the valid bits.
  always_ff @(posedge clk_i) begin
    if (r_state == S_MISS && mem_ready_i) r_line_buf <= mem_rdata_i;
    if (r_state == S_REFILL) begin
      r_data[w_miss_idx] <= r_line_buf;
      r_tag[w_miss_idx]  <= w_miss_tag;
    end
  end

endmodule

// File: tb/tb_segre_icache.sv
// tb_segre_icache: directed bench for segre_icache with a table of hit
// vectors plus hand-written miss, wait, invalidate and reset sequences.
module tb_segre_icache;

  logic         clk = 1'b0;
  logic         rsn;
  logic         fetch_valid;
  logic [31:0]  fetch_addr;
  logic         ic_hit;
  logic [31:0]  instr;
  logic         invalidate;
  logic         mem_rd;
  logic [31:0]  mem_addr;
  logic         mem_ready;
  logic [127:0] mem_rdata;
  logic [31:0]  miss_count;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  segre_icache dut (
    .clk_i         (clk),
    .rsn_i         (rsn),
    .fetch_valid_i (fetch_valid),
    .fetch_addr_i  (fetch_addr),
    .ic_hit_o      (ic_hit),
    .instr_o       (instr),
    .invalidate_i  (invalidate),
    .mem_rd_o      (mem_rd),
    .mem_addr_o    (mem_addr),
    .mem_ready_i   (mem_ready),
    .mem_rdata_i   (mem_rdata),
    .miss_count_o  (miss_count),
    .dbg_state_o   (dbg_state)
  );

  // Clock: 10 ns period.
  always #5 clk = ~clk;

  typedef struct {
    logic        fv;
    logic [31:0] addr;
    logic        exp_hit;
    logic        chk_instr;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs[9];

  localparam logic [127:0] L0 = {32'h193, 32'h113, 32'h093, 32'h013};
  localparam logic [127:0] L1 = {32'h0A3, 32'h0A2, 32'h0A1, 32'h0A0};
  localparam logic [127:0] L2 = {32'h0B3, 32'h0B2, 32'h0B1, 32'h0B0};
  localparam logic [127:0] L3 = {32'h0C3, 32'h0C2, 32'h0C1, 32'h0C0};
  localparam logic [127:0] L4 = {32'h0D3, 32'h0D2, 32'h0D1, 32'h0D0};
  localparam logic [127:0] L5 = {32'h0E3, 32'h0E2, 32'h0E1, 32'h0E0};
  localparam logic [127:0] JUNK = {4{32'hDEAD_BEEF}};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to 2 ns after the next rising edge; inputs are driven there and
  // outputs sampled 1 ns later, well away from either clock edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Run one miss from its LOOKUP cycle to the following LOOKUP cycle.
  // w: memory wait cycles. inv_k: MISS cycle index (0..w) carrying an
  // invalidate pulse, w+1 for the REFILL cycle, -1 for none. Ends in the
  // final LOOKUP cycle without advancing the clock.
  task automatic fill(input logic [31:0] addr, input logic [127:0] line, input int w,
                      input int inv_k, input logic exp_after, input logic [31:0] exp_instr);
    fetch_valid = 1'b1;
    fetch_addr  = addr;
    #1;
    chk("miss_hit_low", {31'd0, ic_hit}, 32'd0);
    chk("lookup_no_rd", {31'd0, mem_rd}, 32'd0);
    cyc();
    for (int k = 0; k <= w; k++) begin
      if (k == w) begin
        mem_ready = 1'b1;
        mem_rdata = line;
      end
      if (k == inv_k) invalidate = 1'b1;
      #1;
      chk("miss_rd", {31'd0, mem_rd}, 32'd1);
      chk("miss_addr", mem_addr, addr & ~32'hF);
      chk("miss_hit_low", {31'd0, ic_hit}, 32'd0);
      chk("miss_state", {30'd0, dbg_state}, 32'd1);
      cyc();
      mem_ready  = 1'b0;
      mem_rdata  = JUNK;
      invalidate = 1'b0;
    end
    if (inv_k == w + 1) invalidate = 1'b1;
    #1;
    chk("refill_hit_low", {31'd0, ic_hit}, 32'd0);
    chk("refill_no_rd", {31'd0, mem_rd}, 32'd0);
    chk("refill_addr0", mem_addr, 32'd0);
    cyc();
    invalidate = 1'b0;
    #1;
    chk("after_fill_hit", {31'd0, ic_hit}, {31'd0, exp_after});
    if (exp_after) chk("after_fill_instr", instr, exp_instr);
  endtask

  initial begin
    rsn         = 1'b0;
    fetch_valid = 1'b0;
    fetch_addr  = 32'd0;
    invalidate  = 1'b0;
    mem_ready   = 1'b0;
    mem_rdata   = JUNK;

    vecs[0] = '{1'b1, 32'h44,  1'b1, 1'b1, 32'h093};
    vecs[1] = '{1'b1, 32'h48,  1'b1, 1'b1, 32'h113};
    vecs[2] = '{1'b1, 32'h4C,  1'b1, 1'b1, 32'h193};
    vecs[3] = '{1'b1, 32'h40,  1'b1, 1'b1, 32'h013};
    vecs[4] = '{1'b1, 32'h47,  1'b1, 1'b1, 32'h093};
    vecs[5] = '{1'b0, 32'h200, 1'b1, 1'b0, 32'h000};
    vecs[6] = '{1'b1, 32'h54,  1'b1, 1'b1, 32'h0A1};
    vecs[7] = '{1'b1, 32'h5C,  1'b1, 1'b1, 32'h0A3};
    vecs[8] = '{1'b1, 32'h58,  1'b1, 1'b1, 32'h0A2};

    // Reset state.
    cyc();
    #1;
    chk("rst_hit_idle", {31'd0, ic_hit}, 32'd1);
    chk("rst_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_count", miss_count, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    fetch_valid = 1'b1;
    fetch_addr  = 32'h40;
    #1;
    chk("rst_hit_fetch", {31'd0, ic_hit}, 32'd0);
    cyc();
    rsn         = 1'b1;
    fetch_valid = 1'b0;
    cyc();

    // Cold miss at 0x40, memory answers in the first MISS cycle.
    fill(32'h40, L0, 0, -1, 1'b1, 32'h013);
    chk("cold_count", miss_count, 32'd1);
    // Second line at index 1 with two wait cycles.
    fill(32'h50, L1, 2, -1, 1'b1, 32'h0A0);
    chk("line1_count", miss_count, 32'd2);
    cyc();

    // Hit table; mem_ready with junk data is held high to show it is ignored.
    mem_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      fetch_valid = vecs[i].fv;
      fetch_addr  = vecs[i].addr;
      #1;
      chk($sformatf("vec%0d_hit", i), {31'd0, ic_hit}, {31'd0, vecs[i].exp_hit});
      if (vecs[i].chk_instr) chk($sformatf("vec%0d_instr", i), instr, vecs[i].exp_instr);
      chk($sformatf("vec%0d_no_rd", i), {31'd0, mem_rd}, 32'd0);
      cyc();
    end
    mem_ready = 1'b0;
    chk("table_count", miss_count, 32'd2);

    // Conflict eviction on index 0, then re-fetch of the evicted line.
    fill(32'h80, L2, 0, -1, 1'b1, 32'h0B0);
    cyc();
    fetch_addr = 32'h84;
    #1;
    chk("conflict_hit84", {31'd0, ic_hit}, 32'd1);
    chk("conflict_instr84", instr, 32'h0B1);
    cyc();
    fetch_addr = 32'h50;
    #1;
    chk("index1_kept", {31'd0, ic_hit}, 32'd1);
    chk("index1_instr", instr, 32'h0A0);
    cyc();
    fill(32'h40, L0, 0, -1, 1'b1, 32'h013);
    chk("conflict_count", miss_count, 32'd4);

    // Memory wait of five cycles: request held for six MISS cycles.
    fill(32'hC0, L5, 5, -1, 1'b1, 32'h0E0);
    chk("wait_count", miss_count, 32'd5);

    // Invalidate during MISS: refilled line dropped, same address requested again.
    fill(32'h1000, L3, 2, 1, 1'b0, 32'h0);
    fill(32'h1000, L3, 0, -1, 1'b1, 32'h0C0);
    chk("inv_miss_count", miss_count, 32'd7);
    fill(32'h50, L1, 0, -1, 1'b1, 32'h0A0);
    chk("inv_old_line_count", miss_count, 32'd8);

    // Invalidate during REFILL is applied to the line being written.
    fill(32'h2000, L4, 0, 1, 1'b0, 32'h0);
    fill(32'h2000, L4, 0, -1, 1'b1, 32'h0D0);
    chk("inv_refill_count", miss_count, 32'd10);
    cyc();

    // Reset during MISS: request drops at once, counter clears.
    fetch_valid = 1'b1;
    fetch_addr  = 32'h3000;
    cyc();
    #1;
    chk("rstmid_rd_before", {31'd0, mem_rd}, 32'd1);
    rsn = 1'b0;
    #1;
    chk("rstmid_rd", {31'd0, mem_rd}, 32'd0);
    chk("rstmid_addr", mem_addr, 32'd0);
    chk("rstmid_count", miss_count, 32'd0);
    chk("rstmid_hit", {31'd0, ic_hit}, 32'd0);
    cyc();
    rsn = 1'b1;
    fill(32'h3000, L3, 1, -1, 1'b1, 32'h0C0);
    chk("rstmid_refetch_count", miss_count, 32'd1);
    cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/segre_icache.md
# segre_icache

Direct-mapped, read-only instruction cache between the IF stage and instruction memory. Looks up the fetch address combinationally and drives the hit flag that the pipeline controller uses to block IF and inject NOPs. On a miss it runs a line-refill handshake with memory, writes the line, and returns to lookup so the held fetch then hits.

## Interface
- ADDR_SIZE, 32, fetch/memory address width
- WORD_SIZE, 32, instruction width; words are 4-byte aligned
- LINE_WORDS, 4, words per line; power of 2, ≥2
- NUM_LINES, 4, number of lines; power of 2, ≥2
- clk_i  in  1  clock; all state updates on rising edge
- rsn_i  in  1  reset; asynchronous, active-low
- fetch_valid_i  in  1  IF stage presents a fetch this cycle
- fetch_addr_i  in  ADDR_SIZE  fetch byte address; bits [1:0] ignored
- ic_hit_o  out  1  high when no fetch or fetch hits; low means stall IF
- instr_o  out  WORD_SIZE  instruction word; meaningful only when fetch_valid_i && ic_hit_o
- invalidate_i  in  1  one-cycle pulse; clears every line's valid bit (fence.i)
- mem_rd_o  out  1  line read request
- mem_addr_o  out  ADDR_SIZE  line-aligned request address (offset bits zero)
- mem_ready_i  in  1  memory returns the line this cycle
- mem_rdata_i  in  LINE_WORDS*WORD_SIZE  line data; word 0 in bits [WORD_SIZE-1:0]
- miss_count_o  out  32  number of refills started since reset

## Operation
- Address split: word select = addr[log2(LINE_WORDS)+1:2]; index = next log2(NUM_LINES) bits; tag = all remaining upper bits.
- Storage per line: valid bit, tag, LINE_WORDS data words. Registers, not SRAM macro.
- FSM states: LOOKUP, MISS, REFILL.
- LOOKUP: hit = valid[index] && tag match. ic_hit_o = !fetch_valid_i || hit. instr_o = selected word of the indexed line (combinational). If fetch_valid_i && !hit: latch line address and index/tag into miss registers, increment miss_count_o (wraps 2^32-1 → 0), go to MISS.
- MISS: mem_rd_o = 1, mem_addr_o = latched line address, both stable until mem_ready_i is sampled high. ic_hit_o = 0 regardless of inputs. On mem_ready_i: capture mem_rdata_i into a line buffer, go to REFILL.
- REFILL: write buffered line and latched tag into the latched index; set valid unless dropped (below). ic_hit_o = 0. Next state LOOKUP.
- mem_rd_o = 0 and mem_addr_o = 0 outside MISS.
- fetch_addr_i or fetch_valid_i changing during MISS/REFILL: refill still completes for the latched address; LOOKUP then re-evaluates the current inputs.
- invalidate_i: clears all valid bits at the clock edge, in any state. If asserted in MISS or REFILL, a drop flag is set (or applied immediately in REFILL) so the refilled line is written with valid = 0. Drop flag clears on entry to LOOKUP.
- mem_ready_i outside MISS is ignored.

## Timing
- Reset (rsn_i low, asynchronous): state = LOOKUP, all valid = 0, drop flag = 0, miss_count_o = 0, mem_rd_o = 0, mem_addr_o = 0. ic_hit_o = !fetch_valid_i; instr_o undefined-but-stable (data array not reset).
- Reset mid-miss: mem_rd_o drops immediately; the in-flight line is discarded.
- Hit: zero-cycle latency; instr_o valid in the same cycle as fetch_addr_i.
- Miss, cycle 0: ic_hit_o = 0 (LOOKUP). Cycle 1: MISS, mem_rd_o = 1. With mem_ready_i high in cycle 1+W, REFILL follows in cycle 2+W, and LOOKUP hits in cycle 3+W. Miss penalty = 3 + W cycles, where W = memory wait cycles (≥0).
- At most one outstanding request. No back-to-back requests without an intervening LOOKUP cycle.

## Test plan
- Cold miss: reset; fetch 0x0000_0040, mem_ready_i in the first MISS cycle with line {0x13,0x93,0x113,0x193} → ic_hit_o low for 3 cycles, mem_addr_o = 0x40, then hit with instr_o = 0x13; miss_count_o = 1.
- Same-line hits: after the fill, fetch 0x44, 0x48, 0x4C → ic_hit_o = 1 each cycle, instr_o = 0x93, 0x113, 0x193; no mem_rd_o.
- Conflict eviction (defaults): fill 0x40, then fetch 0x80 (same index 0, different tag) → miss and refill; re-fetch 0x40 → misses again; miss_count_o = 3.
- Memory wait: mem_ready_i delayed 5 cycles → mem_rd_o and mem_addr_o held stable for 6 cycles; hit arrives in cycle 8 after the miss.
- Invalidate mid-miss: invalidate_i pulse during MISS → the refill completes, but the next LOOKUP misses again and a second request is issued for the same address; previously valid lines also miss.
- Reset mid-miss: drop rsn_i during MISS → mem_rd_o = 0 asynchronously, miss_count_o = 0; after release, the same fetch misses again.
